// File: rtl/snake_pkg.sv
// Shared encodings for the snake body engine.
// Direction one-hots, FSM states, grid size and default head cell.
package snake_pkg;

  localparam int GRID_SIDE = 4;

  localparam logic [3:0] DIR_UP    = 4'b0001;
  localparam logic [3:0] DIR_RIGHT = 4'b0010;
  localparam logic [3:0] DIR_DOWN  = 4'b0100;
  localparam logic [3:0] DIR_LEFT  = 4'b1000;

  localparam logic [3:0] DEF_INIT_HEAD = 4'b0101;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MOVE,
    S_CHECK,
    S_DONE
  } state_t;

endpackage

// File: rtl/snake_next_head.sv
// Wrapped next cell from head and one-hot direction.
// Ports: head, dir in; next_cell out ({row, col}, mod 4).
module snake_next_head
  import snake_pkg::*;
(
  input  logic [3:0] head,
  input  logic [3:0] dir,
  output logic [3:0] next_cell
);

  logic [1:0] row;
  logic [1:0] col;

  assign row = head[3:2];
  assign col = head[1:0];

  // 2-bit arithmetic gives the wrap-around for free
  always_comb begin
    next_cell = head;
    unique case (1'b1)
      dir[0]:  next_cell = {row - 2'd1, col};
      dir[1]:  next_cell = {row, col + 2'd1};
      dir[2]:  next_cell = {row + 2'd1, col};
      dir[3]:  next_cell = {row, col - 2'd1};
      default: next_cell = head;
    endcase
  end

endmodule

// File: rtl/snake_body_engine.sv
// Snake body register file, step FSM, self-collision and apple detect.
// Ports: clock/reset, buttons, step/grow/clear, render read, status.
module snake_body_engine
  import snake_pkg::*;
#(
  parameter int         MAX_SIZE  = 16,
  parameter logic [3:0] INIT_HEAD = DEF_INIT_HEAD
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] buttons,
  input  logic       clear_body,
  input  logic       step,
  input  logic       grow,
  input  logic [3:0] apple_position,
  input  logic [3:0] render_index,
  output logic [3:0] render_position,
  output logic       render_valid,
  output logic [3:0] head_position,
  output logic [4:0] size,
  output logic [3:0] direction,
  output logic       busy,
  output logic       move_done,
  output logic       apple_hit,
  output logic       collision
);

  localparam logic [4:0] MAX_SZ = 5'(MAX_SIZE);

  logic [3:0] body [MAX_SIZE];
  state_t     state;
  logic [4:0] idx;
  logic       grow_q;
  logic [3:0] next_cell;
  logic [3:0] reverse;
  logic       dir_ok;

  snake_next_head u_next (
    .head      (body[0]),
    .dir       (direction),
    .next_cell (next_cell)
  );

  assign head_position   = body[0];
  assign render_position = body[render_index];
  assign render_valid    = ({1'b0, render_index} < size);

  // rotating the one-hot by two swaps up/down and left/right
  assign reverse = {direction[1:0], direction[3:2]};
  assign dir_ok  = $onehot(buttons) &&
                   !((buttons == reverse) && (size > 5'd1));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      size      <= 5'd1;
      direction <= DIR_RIGHT;
      idx       <= 5'd1;
      grow_q    <= 1'b0;
      busy      <= 1'b0;
      move_done <= 1'b0;
      apple_hit <= 1'b0;
      collision <= 1'b0;
      for (int i = 0; i < MAX_SIZE; i++)
        body[i] <= (i == 0) ? INIT_HEAD : 4'd0;
    end else if (clear_body) begin
      state     <= S_IDLE;
      size      <= 5'd1;
      direction <= DIR_RIGHT;
      idx       <= 5'd1;
      grow_q    <= 1'b0;
      busy      <= 1'b0;
      move_done <= 1'b0;
      apple_hit <= 1'b0;
      collision <= 1'b0;
      for (int i = 0; i < MAX_SIZE; i++)
        body[i] <= (i == 0) ? INIT_HEAD : 4'd0;
    end else begin
      if (dir_ok)
        direction <= buttons;
      move_done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (step) begin
            grow_q <= grow;
            busy   <= 1'b1;
            state  <= S_MOVE;
          end
        end
        S_MOVE: begin
          for (int i = 1; i < MAX_SIZE; i++)
            body[i] <= body[i-1];
          body[0] <= next_cell;
          if (grow_q && (size < MAX_SZ))
            size <= size + 5'd1;
          apple_hit <= (next_cell == apple_position);
          idx       <= 5'd1;
          state     <= S_CHECK;
        end
        S_CHECK: begin
          if (idx < size) begin
            if (body[idx[3:0]] == body[0])
              collision <= 1'b1;
            idx <= idx + 5'd1;
          end else begin
            move_done <= 1'b1;
            state     <= S_DONE;
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_snake_body_engine.sv
// Self-checking bench for snake_body_engine.
// Directed scenarios plus random steps against a queue-based snake model.
`timescale 1ns/100ps
module tb_snake_body_engine;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] buttons = '0;
  logic       clear_body = 1'b0;
  logic       step = 1'b0;
  logic       grow = 1'b0;
  logic [3:0] apple_position = '0;
  logic [3:0] render_index = '0;
  logic [3:0] render_position;
  logic       render_valid;
  logic [3:0] head_position;
  logic [4:0] size;
  logic [3:0] direction;
  logic       busy;
  logic       move_done;
  logic       apple_hit;
  logic       collision;

  int total = 0;
  int passed = 0;
  int failed = 0;

  // reference model: body as a queue, head at front
  logic [3:0] mq[$];
  logic [3:0] mdir;
  logic       mcol;

  snake_body_engine dut (
    .clock           (clock),
    .reset           (reset),
    .buttons         (buttons),
    .clear_body      (clear_body),
    .step            (step),
    .grow            (grow),
    .apple_position  (apple_position),
    .render_index    (render_index),
    .render_position (render_position),
    .render_valid    (render_valid),
    .head_position   (head_position),
    .size            (size),
    .direction       (direction),
    .busy            (busy),
    .move_done       (move_done),
    .apple_hit       (apple_hit),
    .collision       (collision)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] m_next(input logic [3:0] h,
                                        input logic [3:0] d);
    int r, c;
    r = h / 4;
    c = h % 4;
    if (d == 4'b0001) r = (r + 3) % 4;
    else if (d == 4'b0100) r = (r + 1) % 4;
    else if (d == 4'b0010) c = (c + 1) % 4;
    else if (d == 4'b1000) c = (c + 3) % 4;
    return 4'(r * 4 + c);
  endfunction

  function automatic logic [3:0] m_opposite(input logic [3:0] d);
    if (d == 4'b0001) return 4'b0100;
    if (d == 4'b0100) return 4'b0001;
    if (d == 4'b0010) return 4'b1000;
    return 4'b0010;
  endfunction

  task automatic m_reset();
    mq.delete();
    mq.push_back(4'b0101);
    mdir = 4'b0010;
    mcol = 1'b0;
  endtask

  task automatic press(input logic [3:0] b);
    if ($countones(b) == 1 &&
        !(b == m_opposite(mdir) && mq.size() > 1))
      mdir = b;
    buttons = b;
    @(negedge clock);
    buttons = '0;
    chk("direction", direction, mdir);
  endtask

  task automatic check_render();
    for (int i = 0; i < 16; i++) begin
      render_index = 4'(i);
      #0.1;
      chk($sformatf("rvalid%0d", i), render_valid, (i < mq.size()));
      if (i < mq.size())
        chk($sformatf("rpos%0d", i), render_position, mq[i]);
    end
    render_index = '0;
  endtask

  task automatic do_step(input logic g);
    logic [3:0] nh;
    logic       ahit;
    int         cnt;
    nh   = m_next(mq[0], mdir);
    ahit = (nh == apple_position);
    mq.push_front(nh);
    if (!(g && mq.size() <= 16))
      void'(mq.pop_back());
    for (int i = 1; i < mq.size(); i++)
      if (mq[i] == mq[0]) mcol = 1'b1;
    step = 1'b1;
    grow = g;
    @(negedge clock);
    step = 1'b0;
    grow = 1'b0;
    chk("busy_move", busy, 1);
    @(negedge clock);
    cnt = 2;
    chk("head", head_position, mq[0]);
    chk("size", size, mq.size());
    chk("apple_hit", apple_hit, ahit);
    while (!move_done && cnt < 40) begin
      @(negedge clock);
      cnt++;
    end
    chk("latency", cnt, mq.size() + 2);
    chk("collision", collision, mcol);
    @(negedge clock);
    chk("busy_idle", busy, 0);
    chk("done_pulse", move_done, 0);
  endtask

  task automatic do_clear();
    clear_body = 1'b1;
    @(negedge clock);
    clear_body = 1'b0;
    m_reset();
    chk("clr_size", size, 1);
  endtask

  initial begin
    int pulses;
    logic [3:0] b;
    m_reset();
    repeat (3) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);

    // reset state
    render_index = 4'd0;
    #0.1;
    chk("rst_head", head_position, 4'b0101);
    chk("rst_size", size, 1);
    chk("rst_dir", direction, 4'b0010);
    chk("rst_valid0", render_valid, 1);
    chk("rst_busy", busy, 0);
    chk("rst_col", collision, 0);
    render_index = 4'd1;
    #0.1;
    chk("rst_valid1", render_valid, 0);
    render_index = 4'd0;

    // wrap: 0101 -> 0110 -> 0111 -> 0100
    do_step(1'b0);
    do_step(1'b0);
    chk("pre_wrap", head_position, 4'b0111);
    do_step(1'b0);
    chk("wrap_head", head_position, 4'b0100);

    // growth and render
    do_clear();
    repeat (3) do_step(1'b1);
    chk("grow_size", size, 4);
    check_render();
    render_index = 4'd3;
    #0.1;
    chk("grow_tail", render_position, 4'b0101);
    render_index = 4'd0;

    // self-collision: up (grow), left, down, right
    press(4'b0001);
    do_step(1'b1);
    chk("sc_size", size, 5);
    chk("sc_col_up", collision, 0);
    press(4'b1000);
    do_step(1'b0);
    chk("sc_col_left", collision, 0);
    press(4'b0100);
    do_step(1'b0);
    chk("sc_col_down", collision, 1);
    press(4'b0010);
    do_step(1'b0);
    chk("sc_sticky", collision, 1);

    // apple hit
    apple_position = m_next(mq[0], mdir);
    do_step(1'b0);
    chk("apple_dir", apple_hit, 1);

    // clear during CHECK aborts the move
    step = 1'b1;
    @(negedge clock);
    step = 1'b0;
    @(negedge clock);
    clear_body = 1'b1;
    @(negedge clock);
    clear_body = 1'b0;
    m_reset();
    chk("abort_busy", busy, 0);
    chk("abort_size", size, 1);
    chk("abort_col", collision, 0);
    chk("abort_head", head_position, 4'b0101);
    pulses = 0;
    for (int i = 0; i < 25; i++) begin
      if (move_done) pulses++;
      @(negedge clock);
    end
    chk("abort_nodone", pulses, 0);

    // reversal filter
    do_step(1'b1);
    press(4'b1000);
    chk("rev_blocked", direction, 4'b0010);
    do_clear();
    press(4'b1000);
    chk("rev_allowed", direction, 4'b1000);

    // random steps
    do_clear();
    for (int n = 0; n < 40; n++) begin
      if (n % 12 == 11) do_clear();
      if ($urandom_range(1, 0) == 1)
        b = 4'(1 << $urandom_range(3, 0));
      else
        b = 4'($urandom_range(15, 0));
      press(b);
      if ($urandom_range(1, 0) == 1)
        apple_position = m_next(mq[0], mdir);
      else
        apple_position = 4'($urandom_range(15, 0));
      do_step(1'($urandom_range(1, 0)));
      if (n % 8 == 7) check_render();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
